// File: rtl/control_division.sv
// ---------------------------------------------------------------------------
// control_division
// Front-end controller for an iterative signed divider. Operand pairs are
// queued in a small FIFO and then sent to the divider one at a time. Each
// result is held until the consumer accepts it. A zero divisor never reaches
// the divider; it produces a flagged result (quotient 0, remainder =
// dividend) directly.
//
// Ports
//   CLK, RSTa           clock, synchronous active-low reset
//   In_Valid/In_Ready   operand handshake; Num_In / Den_In signed operands
//   Div_Start           one-cycle launch pulse to the divider
//   Div_Num / Div_Den   operands to the divider, held until Div_Done
//   Div_Done            divider completion strobe with Div_Coc / Div_Res
//   Out_Valid/Out_Ready result handshake; Coc_Out / Res_Out / Err_Out
// ---------------------------------------------------------------------------
module control_division #(
    parameter int tamanyo = 32,
    parameter int PROF    = 4
) (
    input  logic                      CLK,
    input  logic                      RSTa,
    input  logic                      In_Valid,
    output logic                      In_Ready,
    input  logic signed [tamanyo-1:0] Num_In,
    input  logic signed [tamanyo-1:0] Den_In,
    output logic                      Div_Start,
    output logic signed [tamanyo-1:0] Div_Num,
    output logic signed [tamanyo-1:0] Div_Den,
    input  logic                      Div_Done,
    input  logic signed [tamanyo-1:0] Div_Coc,
    input  logic signed [tamanyo-1:0] Div_Res,
    output logic                      Out_Valid,
    input  logic                      Out_Ready,
    output logic signed [tamanyo-1:0] Coc_Out,
    output logic signed [tamanyo-1:0] Res_Out,
    output logic                      Err_Out
);

    localparam int AW = $clog2(PROF);

    typedef enum logic [1:0] {REPOSO, LANZAR, ESPERA, ENTREGA} estado_t;

    estado_t                   estado;
    logic signed [tamanyo-1:0] num_mem [PROF];
    logic signed [tamanyo-1:0] den_mem [PROF];
    // The extra top bit tells full (top bits differ) from empty (equal).
    logic [AW:0]               wr_ptr;
    logic [AW:0]               rd_ptr;
    logic                      full;
    logic                      empty;
    logic                      push;
    logic                      pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Derived from registered pointers only, so a pop cannot raise it early.
    assign In_Ready = !full;
    assign push     = In_Valid && In_Ready;
    assign pop      = (estado == REPOSO) && !empty;

    // Operand FIFO: pointers are control, storage is plain data.
    always_ff @(posedge CLK) begin
        if (!RSTa) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            num_mem[wr_ptr[AW-1:0]] <= Num_In;
            den_mem[wr_ptr[AW-1:0]] <= Den_In;
        end
    end

    // Sequencer. Div_Num/Div_Den double as the operand registers, so they
    // stay put from the pop until the next pop.
    always_ff @(posedge CLK) begin
        if (!RSTa) begin
            estado    <= REPOSO;
            Div_Start <= 1'b0;
            Div_Num   <= '0;
            Div_Den   <= '0;
            Out_Valid <= 1'b0;
            Coc_Out   <= '0;
            Res_Out   <= '0;
            Err_Out   <= 1'b0;
        end else begin
            Div_Start <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (!empty) begin
                        Div_Num <= num_mem[rd_ptr[AW-1:0]];
                        Div_Den <= den_mem[rd_ptr[AW-1:0]];
                        estado  <= LANZAR;
                    end
                end
                LANZAR: begin
                    if (Div_Den == '0) begin
                        // Divide-by-zero is answered locally, divider untouched.
                        Coc_Out   <= '0;
                        Res_Out   <= Div_Num;
                        Err_Out   <= 1'b1;
                        Out_Valid <= 1'b1;
                        estado    <= ENTREGA;
                    end else begin
                        Div_Start <= 1'b1;
                        estado    <= ESPERA;
                    end
                end
                ESPERA: begin
                    // Divider outputs are meaningful only alongside Div_Done.
                    if (Div_Done) begin
                        Coc_Out   <= Div_Coc;
                        Res_Out   <= Div_Res;
                        Err_Out   <= 1'b0;
                        Out_Valid <= 1'b1;
                        estado    <= ENTREGA;
                    end
                end
                ENTREGA: begin
                    if (Out_Ready) begin
                        Out_Valid <= 1'b0;
                        estado    <= REPOSO;
                    end
                end
                default: estado <= REPOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_control_division.sv
module tb_control_division;

    localparam int W = 32;
    localparam int P = 4;

    logic                CLK;
    logic                RSTa;
    logic                In_Valid;
    logic                In_Ready;
    logic signed [W-1:0] Num_In;
    logic signed [W-1:0] Den_In;
    logic                Div_Start;
    logic signed [W-1:0] Div_Num;
    logic signed [W-1:0] Div_Den;
    logic                Div_Done;
    logic signed [W-1:0] Div_Coc;
    logic signed [W-1:0] Div_Res;
    logic                Out_Valid;
    logic                Out_Ready;
    logic signed [W-1:0] Coc_Out;
    logic signed [W-1:0] Res_Out;
    logic                Err_Out;

    int checks   = 0;
    int failures = 0;

    control_division #(.tamanyo(W), .PROF(P)) dut (
        .CLK(CLK), .RSTa(RSTa),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Num_In(Num_In), .Den_In(Den_In),
        .Div_Start(Div_Start), .Div_Num(Div_Num), .Div_Den(Div_Den),
        .Div_Done(Div_Done), .Div_Coc(Div_Coc), .Div_Res(Div_Res),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Coc_Out(Coc_Out), .Res_Out(Res_Out), .Err_Out(Err_Out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural divider: fixed latency after Start, junk on the data
    // outputs whenever Done is low, optional spurious Done injection.
    int                  lat      = 3;
    bit                  spur     = 1'b0;
    int                  cnt      = 0;
    int                  starts   = 0;
    int                  unstable = 0;
    logic signed [W-1:0] m_num    = '0;
    logic signed [W-1:0] m_den    = 1;
    bit                  full_seen = 1'b0;

    always @(posedge CLK) begin
        if (cnt > 0 && (Div_Num !== m_num || Div_Den !== m_den)) unstable <= unstable + 1;
        if (Div_Start) begin
            starts <= starts + 1;
            m_num  <= Div_Num;
            m_den  <= Div_Den;
            cnt    <= lat;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
        end
        if (cnt == 1 && !Div_Start) begin
            Div_Done <= 1'b1;
            Div_Coc  <= m_num / m_den;
            Div_Res  <= m_num % m_den;
        end else begin
            Div_Done <= spur;
            Div_Coc  <= $signed($urandom);
            Div_Res  <= $signed($urandom);
        end
    end

    task automatic push(input logic signed [W-1:0] n, input logic signed [W-1:0] d, output bit ok);
        ok = 1'b0;
        Num_In = n;
        Den_In = d;
        In_Valid = 1'b1;
        for (int w = 0; w < 100; w++) begin
            if (In_Ready) begin
                @(posedge CLK); #1;
                ok = 1'b1;
                break;
            end
            full_seen = 1'b1;
            @(posedge CLK); #1;
        end
        In_Valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc, output bit ok);
        cyc = 0;
        while (!Out_Valid && cyc < 60) begin
            @(posedge CLK); #1;
            cyc++;
        end
        ok = Out_Valid;
    endtask

    task automatic accept();
        Out_Ready = 1'b1;
        @(posedge CLK); #1;
        Out_Ready = 1'b0;
        checks++;
        if (Out_Valid !== 1'b0) begin
            failures++;
            $display("FAIL accept_clear: Out_Valid=%b required 0", Out_Valid);
        end
    endtask

    task automatic check_result(input string nm, input logic signed [W-1:0] c,
                                input logic signed [W-1:0] r, input logic e);
        checks++;
        if (Coc_Out !== c || Res_Out !== r || Err_Out !== e || Out_Valid !== 1'b1) begin
            failures++;
            $display("FAIL %s: got valid=%b coc=%0d res=%0d err=%b required valid=1 coc=%0d res=%0d err=%b",
                     nm, Out_Valid, Coc_Out, Res_Out, Err_Out, c, r, e);
        end
    endtask

    task automatic check_reset_vals(input string nm);
        checks++;
        if (Out_Valid !== 1'b0 || Div_Start !== 1'b0 || Err_Out !== 1'b0 ||
            Coc_Out !== 0 || Res_Out !== 0 || Div_Num !== 0 || Div_Den !== 0) begin
            failures++;
            $display("FAIL %s: valid=%b start=%b err=%b coc=%0d res=%0d dnum=%0d dden=%0d required all zero",
                     nm, Out_Valid, Div_Start, Err_Out, Coc_Out, Res_Out, Div_Num, Div_Den);
        end
    endtask

    task automatic test_reset();
        RSTa = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_vals("reset_state");
        RSTa = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (In_Ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: In_Ready=%b required 1", In_Ready);
        end
    endtask

    task automatic test_divide(input string nm, input logic signed [W-1:0] n, input logic signed [W-1:0] d,
                               input logic signed [W-1:0] c, input logic signed [W-1:0] r);
        int s0, u0, cyc;
        bit ok, ok2;
        s0 = starts;
        u0 = unstable;
        push(n, d, ok);
        wait_out(cyc, ok2);
        checks++;
        if (!ok || !ok2) begin
            failures++;
            $display("FAIL %s_timeout: push_ok=%b out_ok=%b required 1 1", nm, ok, ok2);
        end
        check_result(nm, c, r, 1'b0);
        checks++;
        if (starts - s0 != 1 || unstable != u0) begin
            failures++;
            $display("FAIL %s_start: start_cycles=%0d unstable=%0d required 1 0", nm, starts - s0, unstable - u0);
        end
        accept();
    endtask

    task automatic test_divzero();
        int s0, cyc;
        bit ok, ok2;
        s0 = starts;
        push(5, 0, ok);
        wait_out(cyc, ok2);
        checks++;
        if (!ok || !ok2 || cyc > 3) begin
            failures++;
            $display("FAIL divzero_latency: cycles=%0d ok=%b/%b required <=3", cyc, ok, ok2);
        end
        check_result("divzero", 0, 5, 1'b1);
        checks++;
        if (starts != s0) begin
            failures++;
            $display("FAIL divzero_nostart: start_cycles=%0d required 0", starts - s0);
        end
        accept();
    endtask

    task automatic test_back_to_back();
        logic signed [W-1:0] bn [6] = '{13, -13, 100, 8, -9, 25};
        logic signed [W-1:0] bd [6] = '{4, 4, 7, 0, -2, 5};
        logic signed [W-1:0] ec [6] = '{3, -3, 14, 0, 4, 5};
        logic signed [W-1:0] er [6] = '{1, -1, 2, 8, -1, 0};
        logic                ee [6] = '{0, 0, 0, 1, 0, 0};
        logic signed [W-1:0] gc [6];
        logic signed [W-1:0] gr [6];
        logic                ge [6];
        int push_fail = 0;
        int got = 0;
        lat = 2;
        Out_Ready = 1'b0;
        full_seen = 1'b0;
        fork
            begin
                bit ok;
                for (int i = 0; i < 6; i++) begin
                    push(bn[i], bd[i], ok);
                    if (!ok) push_fail++;
                end
            end
            begin
                int cyc = 0;
                repeat (30) @(posedge CLK);
                #1;
                Out_Ready = 1'b1;
                while (got < 6 && cyc < 200) begin
                    if (Out_Valid) begin
                        gc[got] = Coc_Out;
                        gr[got] = Res_Out;
                        ge[got] = Err_Out;
                        got++;
                    end
                    @(posedge CLK); #1;
                    cyc++;
                end
                Out_Ready = 1'b0;
            end
        join
        checks++;
        if (push_fail != 0 || !full_seen || got != 6) begin
            failures++;
            $display("FAIL b2b_flow: push_fail=%0d full_seen=%b results=%0d required 0 1 6", push_fail, full_seen, got);
        end
        for (int i = 0; i < got; i++) begin
            checks++;
            if (gc[i] !== ec[i] || gr[i] !== er[i] || ge[i] !== ee[i]) begin
                failures++;
                $display("FAIL b2b_order[%0d]: coc=%0d res=%0d err=%b required coc=%0d res=%0d err=%b",
                         i, gc[i], gr[i], ge[i], ec[i], er[i], ee[i]);
            end
        end
        lat = 3;
    endtask

    task automatic test_hold();
        int cyc, s0;
        bit ok, ok2;
        lat = 12;
        Out_Ready = 1'b0;
        push(50, 6, ok);
        wait_out(cyc, ok2);
        checks++;
        if (!ok || !ok2) begin
            failures++;
            $display("FAIL hold_timeout: push_ok=%b out_ok=%b required 1 1", ok, ok2);
        end
        for (int i = 0; i < 10; i++) begin
            spur = (i == 3);
            @(posedge CLK); #1;
            check_result("hold_stable", 8, 2, 1'b0);
        end
        spur = 1'b0;
        accept();
        s0 = starts;
        spur = 1'b1;
        @(posedge CLK); #1;
        spur = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        checks++;
        if (Out_Valid !== 1'b0 || starts != s0) begin
            failures++;
            $display("FAIL idle_spurious_done: Out_Valid=%b starts=%0d required 0 0", Out_Valid, starts - s0);
        end
        lat = 3;
    endtask

    task automatic test_reset_mid();
        int s0, w;
        bit ok;
        lat = 20;
        s0 = starts;
        push(30, 4, ok);
        w = 0;
        while (starts == s0 && w < 10) begin
            @(posedge CLK); #1;
            w++;
        end
        @(posedge CLK); #1;
        checks++;
        if (starts == s0 || Out_Valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_setup: starts=%0d Out_Valid=%b required 1 0", starts - s0, Out_Valid);
        end
        RSTa = 1'b0;
        @(posedge CLK); #1;
        check_reset_vals("midreset_state");
        checks++;
        if (In_Ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_in_ready: In_Ready=%b required 1", In_Ready);
        end
        RSTa = 1'b1;
        repeat (25) @(posedge CLK);
        #1;
        checks++;
        if (Out_Valid !== 1'b0 || Coc_Out !== 0) begin
            failures++;
            $display("FAIL midreset_late_done: Out_Valid=%b coc=%0d required 0 0", Out_Valid, Coc_Out);
        end
        lat = 3;
        test_divide("after_reset_9_4", 9, 4, 2, 1);
    endtask

    initial begin
        RSTa      = 1'b0;
        In_Valid  = 1'b0;
        Num_In    = '0;
        Den_In    = '0;
        Out_Ready = 1'b0;
        test_reset();
        test_divide("div_7_2", 7, 2, 3, 1);
        test_divide("div_m7_2", -7, 2, -3, -1);
        test_divzero();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_division.md
CONTROL_DIVISION -- requirements
Module: control_division

Interface
REQ-001 SHALL have parameter tamanyo, default 32: operand and result width in bits, two's complement.
REQ-002 SHALL have parameter PROF, default 4: operand FIFO depth, a power of two and at least 2.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port RSTa, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port In_Valid, input, 1 bit: an operand pair is offered.
REQ-006 SHALL have port In_Ready, output, 1 bit: the FIFO can accept a pair.
REQ-007 SHALL have ports Num_In and Den_In, input, tamanyo bits signed each: dividend and divisor.
REQ-008 SHALL have port Div_Start, output, 1 bit: one-cycle start pulse to the divider.
REQ-009 SHALL have ports Div_Num and Div_Den, output, tamanyo bits signed each: operands driven to the divider.
REQ-010 SHALL have port Div_Done, input, 1 bit: divider completion strobe.
REQ-011 SHALL have ports Div_Coc and Div_Res, input, tamanyo bits signed each: divider quotient and remainder.
REQ-012 SHALL have port Out_Valid, output, 1 bit: a result is available.
REQ-013 SHALL have port Out_Ready, input, 1 bit: the consumer accepts the result.
REQ-014 SHALL have ports Coc_Out and Res_Out, output, tamanyo bits signed each: quotient and remainder.
REQ-015 SHALL have port Err_Out, output, 1 bit: the result came from a divide-by-zero.

Function
REQ-016 SHALL accept a pair into the FIFO when In_Valid and In_Ready are both high on a clock edge.
REQ-017 SHALL drive In_Ready = FIFO not full; a pop in the same cycle SHALL NOT raise In_Ready early.
REQ-018 SHALL use an FSM with states REPOSO, LANZAR, ESPERA and ENTREGA.
REQ-019 REPOSO: if the FIFO is not empty, SHALL pop the head into the operand registers and go to LANZAR.
REQ-020 LANZAR with Den non-zero: SHALL assert Div_Start for exactly one cycle and go to ESPERA.
REQ-021 LANZAR with Den == 0: SHALL NOT pulse Div_Start; SHALL load Coc_Out=0, Res_Out=Num, Err_Out=1 and go to ENTREGA.
REQ-022 Div_Num and Div_Den SHALL hold the operand registers, stable from the Start cycle until Done is seen.
REQ-023 ESPERA: on Div_Done high, SHALL capture Div_Coc and Div_Res into Coc_Out/Res_Out, set Err_Out=0 and go to ENTREGA.
REQ-024 ESPERA SHALL ignore Div_Coc and Div_Res in every cycle where Div_Done is low; the wait time is unbounded.
REQ-025 ENTREGA: Out_Valid SHALL be 1; Coc_Out, Res_Out and Err_Out SHALL stay stable while Out_Ready is low.
REQ-026 ENTREGA with Out_Ready high: SHALL clear Out_Valid next cycle and return to REPOSO.
REQ-027 Results SHALL leave in strict FIFO acceptance order; only one division SHALL be outstanding at a time.
REQ-028 Div_Done arriving outside ESPERA SHALL be ignored, with no state or output change.
REQ-029 Minimum latency from push into an empty FIFO to Out_Valid = divider latency + 3 cycles (pop, Start, capture).
REQ-030 FIFO pointers SHALL wrap modulo PROF, with full/empty distinguished by an extra pointer bit.

Reset
REQ-031 With RSTa low at a clock edge: FSM=REPOSO, FIFO empty, Div_Start=0, Out_Valid=0, Err_Out=0; Coc_Out, Res_Out, Div_Num and Div_Den=0.
REQ-032 In_Ready SHALL be 1 from the first edge after reset is released.
REQ-033 Reset during ESPERA or ENTREGA SHALL discard the in-flight operation and all queued pairs; a later Div_Done SHALL be ignored per REQ-028.

Verification
REQ-034 Push (7,2) -> one Div_Start pulse; after Done: Out_Valid=1, Coc_Out=3, Res_Out=1, Err_Out=0.
REQ-035 Push (-7,2) -> Coc_Out=-3, Res_Out=-1, Err_Out=0.
REQ-036 Push (5,0) -> no Div_Start; Coc_Out=0, Res_Out=5, Err_Out=1 within 3 cycles.
REQ-037 Push PROF+2 pairs back-to-back with Out_Ready=0 -> In_Ready falls after the FIFO fills; no pair lost; results emerge in order once Out_Ready=1.
REQ-038 Hold Out_Ready low for 10 cycles in ENTREGA -> outputs unchanged; spurious Div_Done pulse -> no effect.
REQ-039 Assert RSTa low mid-ESPERA -> all outputs at reset values next edge; next push (9,4) -> Coc_Out=2, Res_Out=1.
